// File: rtl/matrix_mul_stream_engine.sv
// Streaming FP32 matrix multiplier: C = A*B from external synchronous RAMs,
// one dot product per output element, results on a valid/ready port.
module matrix_mul_stream_engine #(
  parameter int MAX_M = 16,
  parameter int MAX_K = 16,
  parameter int MAX_N = 16,
  parameter int DIM_W = 5,
  parameter int AW    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [DIM_W-1:0] dim_m,
  input  logic [DIM_W-1:0] dim_k,
  input  logic [DIM_W-1:0] dim_n,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             a_rd_en,
  output logic [AW-1:0]    a_rd_addr,
  input  logic [31:0]      a_rd_data,
  output logic             b_rd_en,
  output logic [AW-1:0]    b_rd_addr,
  input  logic [31:0]      b_rd_data,
  output logic             c_valid,
  input  logic             c_ready,
  output logic [31:0]      c_data,
  output logic [DIM_W-1:0] c_row,
  output logic [DIM_W-1:0] c_col,
  output logic             c_last
);

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_RUN, S_DRAIN, S_OUT, S_FIN
  } state_t;

  state_t r_state, w_next;
  logic [DIM_W-1:0] r_m, r_k, r_n;
  logic [DIM_W-1:0] r_i, r_j, r_kc;
  logic [31:0] r_acc;
  logic r_rd_vld;
  logic w_bad, w_klast, w_last;
  logic [31:0] w_prod, w_sum;

  // Denormals flush to zero; RNE on normal results.
  function automatic logic [31:0] fp_mul(input logic [31:0] a,
                                         input logic [31:0] b);
    logic s, g, st, up;
    logic [7:0] ea, eb;
    logic [47:0] p;
    logic signed [9:0] e;
    logic [23:0] m;
    logic [24:0] r;
    s  = a[31] ^ b[31];
    ea = a[30:23];
    eb = b[30:23];
    p  = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    e  = $signed({2'b0, ea}) + $signed({2'b0, eb}) - 10'sd127;
    if (p[47]) begin
      m  = p[47:24];
      g  = p[23];
      st = |p[22:0];
      e  = e + 10'sd1;
    end else begin
      m  = p[46:23];
      g  = p[22];
      st = |p[21:0];
    end
    up = g & (st | m[0]);
    r  = {1'b0, m} + {24'b0, up};
    if (r[24]) begin
      r = r >> 1;
      e = e + 10'sd1;
    end
    if (ea == 8'hFF || eb == 8'hFF) begin
      if ((ea == 8'hFF && a[22:0] != 0) || (eb == 8'hFF && b[22:0] != 0) ||
          ea == 8'h00 || eb == 8'h00)
        return 32'h7FC00000;
      return {s, 8'hFF, 23'b0};
    end
    if (ea == 8'h00 || eb == 8'h00) return {s, 31'b0};
    if (e >= 10'sd255) return {s, 8'hFF, 23'b0};
    if (e <= 10'sd0) return {s, 31'b0};
    return {s, e[7:0], r[22:0]};
  endfunction

  function automatic logic [31:0] fp_add(input logic [31:0] a,
                                         input logic [31:0] b);
    logic [31:0] x, y;
    logic [7:0] d8;
    logic [4:0] d, lz;
    logic [26:0] mx, my, mys;
    logic [53:0] sh;
    logic [27:0] s;
    logic signed [9:0] e;
    logic [24:0] r;
    logic g, st, up, found;
    if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) begin
      if ((a[30:23] == 8'hFF && a[22:0] != 0) ||
          (b[30:23] == 8'hFF && b[22:0] != 0) ||
          (a[30:23] == 8'hFF && b[30:23] == 8'hFF && a[31] != b[31]))
        return 32'h7FC00000;
      return (a[30:23] == 8'hFF) ? a : b;
    end
    if (a[30:23] == 8'h00 && b[30:23] == 8'h00) return {a[31] & b[31], 31'b0};
    if (a[30:23] == 8'h00) return b;
    if (b[30:23] == 8'h00) return a;
    if (a[30:0] < b[30:0]) begin
      x = b;
      y = a;
    end else begin
      x = a;
      y = b;
    end
    d8  = x[30:23] - y[30:23];
    d   = (d8 > 8'd31) ? 5'd31 : d8[4:0];
    mx  = {1'b1, x[22:0], 3'b0};
    my  = {1'b1, y[22:0], 3'b0};
    sh  = {my, 27'b0} >> d;
    mys = {sh[53:28], sh[27] | (|sh[26:0])};
    e   = $signed({2'b0, x[30:23]});
    if (x[31] == y[31]) begin
      s = {1'b0, mx} + {1'b0, mys};
      if (s[27]) begin
        s = {1'b0, s[27:2], s[1] | s[0]};
        e = e + 10'sd1;
      end
    end else begin
      s = {1'b0, mx} - {1'b0, mys};
      if (s == 28'd0) return 32'h0;
      lz = 5'd0;
      found = 1'b0;
      for (int q = 26; q >= 0; q--) begin
        if (!found) begin
          if (s[q]) found = 1'b1;
          else lz = lz + 5'd1;
        end
      end
      s = s << lz;
      e = e - $signed({5'b0, lz});
    end
    g  = s[2];
    st = |s[1:0];
    up = g & (st | s[3]);
    r  = {1'b0, s[26:3]} + {24'b0, up};
    if (r[24]) begin
      r = r >> 1;
      e = e + 10'sd1;
    end
    if (e >= 10'sd255) return {x[31], 8'hFF, 23'b0};
    if (e <= 10'sd0) return {x[31], 31'b0};
    return {x[31], e[7:0], r[22:0]};
  endfunction

  assign w_bad = (r_m == '0) || (r_m > DIM_W'(MAX_M)) ||
                 (r_k == '0) || (r_k > DIM_W'(MAX_K)) ||
                 (r_n == '0) || (r_n > DIM_W'(MAX_N));
  assign w_klast = (r_kc == r_k - DIM_W'(1));
  assign w_last  = (r_i == r_m - DIM_W'(1)) && (r_j == r_n - DIM_W'(1));
  assign w_prod  = fp_mul(a_rd_data, b_rd_data);
  assign w_sum   = fp_add(r_acc, w_prod);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    busy      = (r_state != S_IDLE);
    done      = 1'b0;
    err       = 1'b0;
    a_rd_en   = 1'b0;
    b_rd_en   = 1'b0;
    a_rd_addr = '0;
    b_rd_addr = '0;
    c_valid   = 1'b0;
    c_data    = '0;
    c_row     = '0;
    c_col     = '0;
    c_last    = 1'b0;
    case (r_state)
      S_IDLE:  if (start) w_next = S_CHECK;
      S_CHECK: w_next = w_bad ? S_FIN : S_RUN;
      S_RUN: begin
        a_rd_en   = 1'b1;
        b_rd_en   = 1'b1;
        a_rd_addr = AW'(r_i) * AW'(r_k) + AW'(r_kc);
        b_rd_addr = AW'(r_kc) * AW'(r_n) + AW'(r_j);
        if (w_klast) w_next = S_DRAIN;
      end
      S_DRAIN: w_next = S_OUT;
      S_OUT: begin
        c_valid = 1'b1;
        c_data  = r_acc;
        c_row   = r_i;
        c_col   = r_j;
        c_last  = w_last;
        if (c_ready) w_next = w_last ? S_FIN : S_RUN;
      end
      S_FIN: begin
        done   = 1'b1;
        err    = w_bad;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Product of the read issued last cycle lands in acc this cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_m      <= '0;
      r_k      <= '0;
      r_n      <= '0;
      r_i      <= '0;
      r_j      <= '0;
      r_kc     <= '0;
      r_acc    <= '0;
      r_rd_vld <= 1'b0;
    end else begin
      r_rd_vld <= (r_state == S_RUN);
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_m <= dim_m;
            r_k <= dim_k;
            r_n <= dim_n;
          end
        end
        S_CHECK: begin
          r_i   <= '0;
          r_j   <= '0;
          r_kc  <= '0;
          r_acc <= '0;
        end
        S_RUN: begin
          r_kc <= r_kc + DIM_W'(1);
          if (r_rd_vld) r_acc <= w_sum;
        end
        S_DRAIN: r_acc <= w_sum;
        S_OUT: begin
          if (c_ready && !w_last) begin
            r_kc  <= '0;
            r_acc <= '0;
            if (r_j == r_n - DIM_W'(1)) begin
              r_j <= '0;
              r_i <= r_i + DIM_W'(1);
            end else begin
              r_j <= r_j + DIM_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_mul_stream_engine.sv
// Bench for matrix_mul_stream_engine: integer-valued matrices, expected C
// computed as exact integer dot products converted to FP32.
module tb_matrix_mul_stream_engine;

  localparam int DW = 5;
  localparam int AW = 8;

  logic clk, rst_n, start;
  logic [DW-1:0] dim_m, dim_k, dim_n;
  logic busy, done, err;
  logic a_rd_en, b_rd_en;
  logic [AW-1:0] a_rd_addr, b_rd_addr;
  logic [31:0] a_rd_data, b_rd_data;
  logic c_valid, c_ready, c_last;
  logic [31:0] c_data;
  logic [DW-1:0] c_row, c_col;

  matrix_mul_stream_engine dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .dim_m(dim_m), .dim_k(dim_k), .dim_n(dim_n),
    .busy(busy), .done(done), .err(err),
    .a_rd_en(a_rd_en), .a_rd_addr(a_rd_addr), .a_rd_data(a_rd_data),
    .b_rd_en(b_rd_en), .b_rd_addr(b_rd_addr), .b_rd_data(b_rd_data),
    .c_valid(c_valid), .c_ready(c_ready), .c_data(c_data),
    .c_row(c_row), .c_col(c_col), .c_last(c_last)
  );

  typedef struct {
    int i;
    int j;
    logic [31:0] d;
    logic l;
  } elem_t;

  elem_t q[$];
  int total = 0, bad = 0;
  int ai[16][16], bi[16][16];
  logic [31:0] ram_a[256], ram_b[256];
  int cur_k, cur_n, rd_k;
  int done_cnt = 0, hs_cnt = 0;
  bit seen_rd, seen_cv, exp_done, p_stall;
  logic [31:0] sv_d;
  logic [DW-1:0] sv_r, sv_c;
  int stall_left = 0, stall_r = 0, stall_c = 1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (a_rd_en) a_rd_data <= ram_a[a_rd_addr];
    if (b_rd_en) b_rd_data <= ram_b[b_rd_addr];
  end

  function automatic void chk(string nm, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, got, exp);
    end
  endfunction

  function automatic logic [31:0] int2fp(input int v);
    int mag, p;
    logic [31:0] mm;
    if (v == 0) return 32'h0;
    mag = (v < 0) ? -v : v;
    p = 0;
    for (int t = 0; t < 24; t++) if (mag[t]) p = t;
    mm = 32'(mag) << (23 - p);
    return {(v < 0), 8'(127 + p), mm[22:0]};
  endfunction

  // Consumer: hold c_ready low for stall_left cycles on one chosen element.
  initial begin
    c_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      if (stall_left > 0 && c_valid && int'(c_row) == stall_r &&
          int'(c_col) == stall_c) begin
        c_ready = 1'b0;
        stall_left--;
      end else begin
        c_ready = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      rd_k = 0;
      p_stall = 0;
      exp_done = 0;
    end else begin
      if (exp_done) chk("done_after_last", done, 1);
      exp_done = 0;
      if (done) done_cnt++;
      if (a_rd_en || b_rd_en) seen_rd = 1;
      if (c_valid) seen_cv = 1;
      if (a_rd_en) begin
        chk("rd_en_pair", b_rd_en, 1);
        chk("rd_while_valid", c_valid, 0);
        chk("rd_q_nonempty", q.size() != 0, 1);
        chk("rd_k_range", rd_k < cur_k, 1);
        if (q.size() != 0) begin
          chk("a_addr", a_rd_addr, 32'(q[0].i * cur_k + rd_k));
          chk("b_addr", b_rd_addr, 32'(rd_k * cur_n + q[0].j));
        end
        rd_k++;
      end
      if (p_stall) begin
        chk("stall_valid", c_valid, 1);
        chk("stall_data", c_data, sv_d);
        chk("stall_row", c_row, sv_r);
        chk("stall_col", c_col, sv_c);
      end
      p_stall = 0;
      if (c_valid) begin
        chk("out_q_nonempty", q.size() != 0, 1);
        chk("reads_per_elem", rd_k, cur_k);
        if (q.size() != 0) begin
          chk("c_row", c_row, q[0].i);
          chk("c_col", c_col, q[0].j);
          chk("c_data", c_data, q[0].d);
          chk("c_last", c_last, q[0].l);
        end
        if (c_ready) begin
          hs_cnt++;
          if (c_last) exp_done = 1;
          if (q.size() != 0) void'(q.pop_front());
          rd_k = 0;
        end else begin
          p_stall = 1;
          sv_d = c_data;
          sv_r = c_row;
          sv_c = c_col;
        end
      end
    end
  end

  task automatic check_idle_outputs(string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_a_en"}, a_rd_en, 0);
    chk({tag, "_b_en"}, b_rd_en, 0);
    chk({tag, "_a_addr"}, a_rd_addr, 0);
    chk({tag, "_valid"}, c_valid, 0);
    chk({tag, "_data"}, c_data, 0);
    chk({tag, "_last"}, c_last, 0);
  endtask

  task automatic run_job(input int m, input int k, input int n,
                         input bit rej, input int glitch,
                         input int abort, input int stall);
    int cyc, nv, bz, d0, h0, s;
    bit fin, aborted, got_done, got_err, vseen;
    q.delete();
    cur_k = k;
    cur_n = n;
    if (!rej) begin
      for (int i = 0; i < m; i++)
        for (int j = 0; j < n; j++) begin
          s = 0;
          for (int kk = 0; kk < k; kk++) s += ai[i][kk] * bi[kk][j];
          q.push_back('{i, j, int2fp(s), (i == m - 1 && j == n - 1)});
        end
      for (int i = 0; i < m; i++)
        for (int kk = 0; kk < k; kk++) ram_a[i * k + kk] = int2fp(ai[i][kk]);
      for (int kk = 0; kk < k; kk++)
        for (int j = 0; j < n; j++) ram_b[kk * n + j] = int2fp(bi[kk][j]);
    end
    stall_left = stall;
    seen_rd = 0;
    seen_cv = 0;
    d0 = done_cnt;
    h0 = hs_cnt;
    @(posedge clk);
    #2;
    start = 1'b1;
    dim_m = DW'(m);
    dim_k = DW'(k);
    dim_n = DW'(n);
    @(posedge clk);
    #2;
    start = 1'b0;
    cyc = 0; nv = 0; bz = 0;
    fin = 0; aborted = 0; got_done = 0; got_err = 0; vseen = 0;
    while (!fin && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      if (busy) bz++;
      if (c_valid && !vseen) begin
        vseen = 1;
        nv = cyc;
      end
      if (done) begin
        got_done = 1;
        got_err = err;
        fin = 1;
      end
      if (cyc == glitch) begin
        start = 1'b1;
        dim_m = 1;
        dim_k = 1;
        dim_n = 1;
      end
      if (cyc == glitch + 1) start = 1'b0;
      if (cyc == abort) begin
        rst_n = 1'b0;
        #1;
        check_idle_outputs("abort");
        aborted = 1;
        fin = 1;
      end
    end
    if (aborted) begin
      repeat (3) begin
        @(negedge clk);
        chk("abort_no_done", done, 0);
      end
      chk("abort_done_cnt", done_cnt - d0, 0);
      @(posedge clk);
      #2;
      stall_left = 0;
      q.delete();
      rst_n = 1'b1;
      return;
    end
    chk("done_seen", got_done, 1);
    chk("err_flag", got_err, rej);
    @(negedge clk);
    chk("done_pulse", done, 0);
    chk("idle_busy", busy, 0);
    chk("done_count", done_cnt - d0, 1);
    chk("handshakes", hs_cnt - h0, rej ? 0 : m * n);
    chk("q_empty", q.size(), 0);
    if (rej) begin
      chk("rej_busy_cycles", bz, 2);
      chk("rej_no_reads", seen_rd, 0);
      chk("rej_no_valid", seen_cv, 0);
    end else begin
      chk("first_valid_lat", nv, k + 3);
    end
  endtask

  task automatic set_mixed();
    for (int i = 0; i < 16; i++)
      for (int kk = 0; kk < 16; kk++) begin
        ai[i][kk] = ((i * 3 + kk * 5) % 7) - 3;
        bi[i][kk] = ((i * 2 + kk * 3) % 9) - 4;
      end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    dim_m = '0;
    dim_k = '0;
    dim_n = '0;
    #12;
    check_idle_outputs("reset");
    @(posedge clk);
    #2;
    rst_n = 1'b1;

    chk("model_neg6", int2fp(-6), 32'hC0C00000);
    chk("model_6", int2fp(6), 32'h40C00000);
    chk("model_16", int2fp(16), 32'h41800000);
    chk("model_3", int2fp(3), 32'h40400000);

    ai[0][0] = 3;
    bi[0][0] = -2;
    run_job(1, 1, 1, 0, -1, -1, 0);

    for (int i = 0; i < 2; i++)
      for (int kk = 0; kk < 3; kk++) ai[i][kk] = 1;
    for (int kk = 0; kk < 3; kk++)
      for (int j = 0; j < 2; j++) bi[kk][j] = kk + 1;
    run_job(2, 3, 2, 0, -1, -1, 0);
    run_job(2, 3, 2, 0, -1, -1, 5);

    set_mixed();
    run_job(2, 3, 2, 0, -1, -1, 0);
    run_job(3, 2, 4, 0, -1, -1, 0);
    run_job(4, 5, 3, 0, -1, -1, 2);

    run_job(2, 0, 2, 1, -1, -1, 0);
    run_job(17, 2, 2, 1, -1, -1, 0);

    run_job(2, 3, 2, 0, 3, -1, 0);
    run_job(2, 3, 2, 0, -1, 4, 0);
    run_job(2, 3, 2, 0, -1, -1, 0);

    for (int i = 0; i < 16; i++)
      for (int kk = 0; kk < 16; kk++) begin
        ai[i][kk] = 1;
        bi[i][kk] = 1;
      end
    run_job(16, 16, 16, 0, -1, -1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/matrix_mul_stream_engine.md
Name: matrix_mul_stream_engine

Overview:
- Next-generation FP32 matrix multiplier. Computes C[M×N] = A[M×K] · B[K×N].
- M, K and N are runtime inputs, bounded by synthesis-time maxima.
- Operands are not wide flat arrays. A and B are read from external synchronous RAMs, both row-major with runtime strides.
- C elements stream out row-major on a valid/ready interface. This supports backpressure and removes the MAX_M·MAX_N output register file.

Parameters:
- MAX_M, 16, largest legal M.
- MAX_K, 16, largest legal K.
- MAX_N, 16, largest legal N.
- DIM_W, 5, width of dim inputs and of c_row/c_col. Must hold MAX_*+1.
- AW, 8, A/B RAM address width. Must hold MAX_M·MAX_K−1 and MAX_K·MAX_N−1.

Ports:
- clk, in, 1, single clock, rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- start, in, 1, request a job. Sampled only in IDLE.
- dim_m, in, DIM_W, M. Latched on start.
- dim_k, in, DIM_W, K. Latched on start.
- dim_n, in, DIM_W, N. Latched on start.
- busy, out, 1, high in every state except IDLE.
- done, out, 1, one-cycle pulse at end of job, including a rejected job.
- err, out, 1, one-cycle pulse together with done when the dims are illegal.
- a_rd_en, out, 1, A RAM read enable.
- a_rd_addr, out, AW, A RAM read address.
- a_rd_data, in, 32, A RAM read data. Valid the cycle after a_rd_en.
- b_rd_en, out, 1, B RAM read enable.
- b_rd_addr, out, AW, B RAM read address.
- b_rd_data, in, 32, B RAM read data. Valid the cycle after b_rd_en.
- c_valid, out, 1, C element available.
- c_ready, in, 1, consumer accepts the element.
- c_data, out, 32, FP32 C[i][j].
- c_row, out, DIM_W, i.
- c_col, out, DIM_W, j.
- c_last, out, 1, high with the final element (i=M−1, j=N−1).

Behaviour:
- Reset (asynchronous, any state):
  - State goes to IDLE.
  - All outputs go to 0, and the accumulator and counters go to 0.
  - Any job in flight is abandoned. No done pulse is produced.
- States: IDLE, CHECK, RUN, DRAIN, OUT, FIN.
- IDLE:
  - start=1 latches dims and moves to CHECK.
  - start is ignored in every other state.
- CHECK (1 cycle):
  - If any dim is 0 or exceeds its MAX, go to FIN with err flagged. No RAM reads are issued.
  - Otherwise set i=j=k=0, acc=+0.0 (0x00000000), and go to RUN.
- RUN:
  - Each cycle assert a_rd_en and b_rd_en with a_rd_addr=i·K+k and b_rd_addr=k·N+j, then increment k.
  - The issue at k=K−1 moves to DRAIN.
- Accumulation:
  - On every cycle following a read issue (in RUN or DRAIN), acc ← fp32_add(acc, fp32_mul(a_rd_data, b_rd_data)).
  - fp32_mul and fp32_add are the codebase's combinational units: IEEE-754 single, round-to-nearest-even, two separate roundings (not fused).
- DRAIN (1 cycle): absorbs the last product, then moves to OUT.
- OUT:
  - c_valid=1; c_data=acc; c_row=i; c_col=j; c_last=(i==M−1 && j==N−1).
  - All outputs stay stable while c_ready=0.
  - When c_valid&&c_ready:
    - If c_last, go to FIN.
    - Otherwise advance j, wrapping to 0 and incrementing i. Clear acc to +0.0, set k=0, and go to RUN.
- FIN (1 cycle): done=1, err=the flag from CHECK. Then return to IDLE, where busy=0.
- Latency:
  - Start accepted at edge t0 → CHECK at t1 → first read at t2.
  - First c_valid asserts K+2 cycles after CHECK, i.e. t0+K+3.
  - Each subsequent element appears K+2 cycles after the previous handshake.
  - done asserts the cycle after the final handshake.
- Width rules:
  - Address products are computed at AW bits with no overflow, guaranteed by the parameter constraint.
  - c_row/c_col are zero-extended.
- Back-to-back jobs: start may be asserted in the same cycle that busy falls (IDLE). That job is accepted normally.
- NaN, Inf and denormal operands pass through whatever the FP units produce. No special-case handling.

Test Plan:
- M=K=N=1, A0=0x40400000 (3.0), B0=0xC0000000 (−2.0) → one element: c_data=0xC0C00000, c_last=1, c_valid 4 cycles after start, done the cycle after the handshake.
- M=2,K=3,N=2, A all 1.0 (0x3F800000), B[k][j]=k+1 → four elements, row-major (0,0),(0,1),(1,0),(1,1), each 6.0 (0x40C00000). Check the a/b_rd_addr sequences use strides K=3 and N=2.
- Same job with c_ready held low for 5 cycles during element (0,1) → c_data, c_row and c_col stable, no new reads issued, exactly 4 handshakes total.
- dim_k=0, then dim_m=MAX_M+1 → CHECK rejects: done=1 and err=1 on the same cycle, a_rd_en/b_rd_en never asserted, c_valid never asserted, busy high for 2 cycles.
- start pulsed during RUN → ignored, dims unchanged. Then rst_n=0 mid-RUN → all outputs 0 immediately, IDLE, no done. A new job after reset completes correctly.
- M=K=N=16, all operands 1.0 → 256 elements each 0x41800000 (16.0), c_last only on (15,15), done once.
